instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction-fetch stage feeding the MIPS control/datapath. Holds the PC and fetches
//  one 32-bit word per instruction from instruction memory over a req/ready handshake.
//  Presents instr (op = instr[31:26], funct = instr[5:0]) to the controller. Computes the
//  next PC from the controller's pcsrc/jump decisions when downstream signals advance.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC value loaded on reset; must be word aligned
// PORTS
//  clk          input   1    single clock; all state changes on posedge
//  reset_n      input   1    asynchronous, active-low reset
//  imem_req     output  1    fetch request; imem_addr valid while high
//  imem_addr    output  32   word address to instruction memory (= pc)
//  imem_rdata   input   32   instruction word; sampled when imem_req & imem_ready
//  imem_ready   input   1    memory has imem_rdata valid this cycle
//  instr        output  32   current instruction, stable while instr_valid
//  instr_valid  output  1    instr holds a fetched, not-yet-retired instruction
//  pc           output  32   address of current instruction
//  pcplus4      output  32   pc + 4 (combinational)
//  advance      input   1    downstream finished instr; commit next PC this edge
//  pcsrc        input   1    branch taken (branch & zero); sampled only on advance
//  jump         input   1    jump instruction; sampled only on advance
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0,
//   imem_req=0. Outputs hold these values for as long as reset_n is low.
//  FSM: IDLE -> FETCH unconditionally on the first posedge after reset release.
//   FETCH: imem_req=1. On posedge with imem_ready=1: instr<=imem_rdata,
//    instr_valid<=1 -> HOLD. Otherwise stay in FETCH; pc and imem_addr stay stable.
//   HOLD: imem_req=0, instr_valid=1. On posedge with advance=1: pc<=pcnext,
//    instr_valid<=0 -> FETCH. Otherwise hold; instr stays unchanged.
//  advance is ignored outside HOLD. imem_ready is ignored outside FETCH.
//  imem_req is decoded from the state register only; no path from imem_ready.
//  Next PC, computed from the held instr (signimm = sign-extended instr[15:0]):
//   pcbranch = pcplus4 + (signimm << 2)          (32-bit, modulo 2^32)
//   jta      = {pcplus4[31:28], instr[25:0], 2'b00}
//   pcnext   = jump ? jta : (pcsrc ? pcbranch : pcplus4)  -- jump has priority
//  Wrap-around: pc=32'hFFFF_FFFC gives pcplus4=32'h0; a branch may wrap either way.
//   No overflow flag is raised.
//  pc[1:0] is always 2'b00, since every PC source is word aligned.
//  Throughput: at least 2 cycles per instruction (1 FETCH with ready + 1 HOLD with advance).
//  Fetch latency: instr_valid rises on the edge after imem_ready is seen in FETCH.
//  Reset mid-operation: any state returns to IDLE at once. An in-flight request is
//   dropped (imem_req falls asynchronously). The memory must tolerate an abandoned request.
//  advance together with pcsrc=1 and jump=1: jump target is used.
//  Unknown/illegal state encoding: recover to IDLE.
// TESTING
//  1 Reset: RESET_PC=32'h100, hold reset_n=0 -> imem_req=0, pc=32'h100, instr_valid=0;
//    release -> imem_req=1 one edge later, imem_addr=32'h100.
//  2 Sequential: ready=1 every FETCH, advance=1 every HOLD, pcsrc=jump=0 ->
//    pc sequence 0x100,0x104,0x108, one instruction per 2 cycles.
//  3 Wait states: imem_ready held low 3 cycles -> imem_req and imem_addr stable;
//    instr_valid rises the edge after ready=1.
//  4 Branch: instr=32'h1000_FFFF (beq, imm=-1) at pc=0x200, pcsrc=1 on advance ->
//    next pc=0x200; with imm=16'h0003 -> 0x210.
//  5 Jump priority: instr=32'h0800_0040 at pc=0x3000_0000, jump=1 and pcsrc=1 ->
//    next pc=0x3000_0100.
//  6 Wrap and stall: pc=32'hFFFF_FFFC, advance -> pc=0; advance held low 5 cycles
//    in HOLD -> instr and pc unchanged. reset_n pulsed low mid-FETCH -> IDLE, pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Instruction-fetch stage for the MIPS core. It owns the PC, fetches one
// instruction word per instruction over a req/ready handshake, holds the word
// for the controller, and commits the next PC (sequential, branch or jump)
// when the downstream stages say the instruction is finished.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  input  logic        advance,
  input  logic        pcsrc,
  input  logic        jump
);

  // The low two PC bits are forced to zero so the word-alignment invariant
  // survives even a carelessly chosen RESET_PC.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  // IDLE is the post-reset parking state, FETCH waits for memory, and HOLD
  // keeps the fetched word until the downstream stages retire it. The spare
  // encoding 2'b11 is illegal and steers back to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10
  } state_t;

  state_t state;
  state_t state_next;

  logic        fetch_done;
  logic        retire;
  logic [31:0] branch_offset;
  logic [31:0] pcbranch;
  logic [31:0] jta;
  logic [31:0] pcnext;

  // A fetch completes only while a request is outstanding; an instruction is
  // retired only while one is held. Everything else is ignored.
  assign fetch_done = (state == FETCH) && imem_ready;
  assign retire     = (state == HOLD) && advance;

  // Next-PC arithmetic. The branch offset is the sign-extended immediate
  // already shifted left by two, built directly so no upper bits are wasted.
  // All sums wrap modulo 2^32 and no overflow indication exists.
  assign pcplus4       = pc + 32'd4;
  assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign pcbranch      = pcplus4 + branch_offset;
  assign jta           = {pcplus4[31:28], instr[25:0], 2'b00};
  assign pcnext        = jump ? jta : (pcsrc ? pcbranch : pcplus4);

  assign imem_addr = pc;

  // State register: asynchronous reset parks the FSM in IDLE immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: leave IDLE unconditionally, wait for memory in FETCH,
  // wait for retirement in HOLD, and recover from an illegal encoding.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH:   state_next = imem_ready ? HOLD : FETCH;
      HOLD:    state_next = advance ? FETCH : HOLD;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the state register only, so imem_req has no
  // combinational path from imem_ready and instr_valid tracks HOLD exactly.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      FETCH:   imem_req    = 1'b1;
      HOLD:    instr_valid = 1'b1;
      default: begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
      end
    endcase
  end

  // Datapath registers: capture the instruction word when memory answers and
  // commit the chosen next PC when the held instruction is retired.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc    <= RESET_PC_ALIGNED;
      instr <= 32'h0000_0000;
    end else begin
      if (fetch_done) begin
        instr <= imem_rdata;
      end
      if (retire) begin
        pc <= pcnext;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
// Directed self-checking bench for the instruction-fetch stage. The main
// instance starts at 0x100; a second instance starts at 0x3000_0000 so the
// jump-region behaviour can be exercised without a long walk of the PC.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset_n;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        advance;
  logic        pcsrc;
  logic        jump;

  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic [31:0] imem_rdata2;
  logic        imem_ready2;
  logic [31:0] instr2;
  logic        instr_valid2;
  logic [31:0] pc2;
  logic [31:0] pcplus4_2;
  logic        advance2;
  logic        pcsrc2;
  logic        jump2;

  int n_compared;
  int n_mismatched;

  instr_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pcplus4     (pcplus4),
    .advance     (advance),
    .pcsrc       (pcsrc),
    .jump        (jump)
  );

  instr_fetch_unit #(.RESET_PC(32'h3000_0000)) dut2 (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req2),
    .imem_addr   (imem_addr2),
    .imem_rdata  (imem_rdata2),
    .imem_ready  (imem_ready2),
    .instr       (instr2),
    .instr_valid (instr_valid2),
    .pc          (pc2),
    .pcplus4     (pcplus4_2),
    .advance     (advance2),
    .pcsrc       (pcsrc2),
    .jump        (jump2)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of main-instance inputs from a falling edge, then return
  // all of them to idle at the next falling edge.
  task automatic applyStimulus(input logic rdy, input logic [31:0] rd,
                               input logic adv, input logic ps, input logic jp);
    imem_ready = rdy;
    imem_rdata = rd;
    advance    = adv;
    pcsrc      = ps;
    jump       = jp;
    @(negedge clk);
    imem_ready = 1'b0;
    advance    = 1'b0;
    pcsrc      = 1'b0;
    jump       = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_compared++; if (imem_req !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_req: got %b want 0", imem_req); end
    n_compared++; if (pc !== 32'h0000_0100) begin n_mismatched++; $display("[TB] FAIL reset_pc: got %h want 00000100", pc); end
    n_compared++; if (instr_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_valid: got %b want 0", instr_valid); end
    n_compared++; if (instr !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_instr: got %h want 00000000", instr); end
    n_compared++; if (pc2 !== 32'h3000_0000) begin n_mismatched++; $display("[TB] FAIL reset_pc2: got %h want 30000000", pc2); end
    reset_n = 1'b1;
    #1;
    n_compared++; if (imem_req !== 1'b0) begin n_mismatched++; $display("[TB] FAIL release_req_idle: got %b want 0", imem_req); end
    @(negedge clk);
    n_compared++; if (imem_req !== 1'b1) begin n_mismatched++; $display("[TB] FAIL release_req: got %b want 1", imem_req); end
    n_compared++; if (imem_addr !== 32'h0000_0100) begin n_mismatched++; $display("[TB] FAIL release_addr: got %h want 00000100", imem_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    logic [31:0] word;
    exp_pc = 32'h0000_0100;
    for (int i = 0; i < 3; i++) begin
      word = 32'h2008_0000 + i;
      n_compared++; if (pc !== exp_pc) begin n_mismatched++; $display("[TB] FAIL seq_pc[%0d]: got %h want %h", i, pc, exp_pc); end
      n_compared++; if (imem_req !== 1'b1) begin n_mismatched++; $display("[TB] FAIL seq_req[%0d]: got %b want 1", i, imem_req); end
      applyStimulus(1'b1, word, 1'b0, 1'b0, 1'b0);
      n_compared++; if (instr_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL seq_valid[%0d]: got %b want 1", i, instr_valid); end
      n_compared++; if (instr !== word) begin n_mismatched++; $display("[TB] FAIL seq_instr[%0d]: got %h want %h", i, instr, word); end
      n_compared++; if (imem_req !== 1'b0) begin n_mismatched++; $display("[TB] FAIL seq_req_hold[%0d]: got %b want 0", i, imem_req); end
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      exp_pc = exp_pc + 32'd4;
    end
    n_compared++; if (pc !== 32'h0000_010C) begin n_mismatched++; $display("[TB] FAIL seq_pc_end: got %h want 0000010c", pc); end
    n_compared++; if (instr_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL seq_valid_end: got %b want 0", instr_valid); end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
      n_compared++; if (imem_req !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wait_req[%0d]: got %b want 1", i, imem_req); end
      n_compared++; if (imem_addr !== 32'h0000_010C) begin n_mismatched++; $display("[TB] FAIL wait_addr[%0d]: got %h want 0000010c", i, imem_addr); end
      n_compared++; if (instr_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL wait_valid[%0d]: got %b want 0", i, instr_valid); end
    end
    applyStimulus(1'b1, 32'h8C08_0010, 1'b0, 1'b0, 1'b0);
    n_compared++; if (instr_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wait_valid_rise: got %b want 1", instr_valid); end
    n_compared++; if (instr !== 32'h8C08_0010) begin n_mismatched++; $display("[TB] FAIL wait_instr: got %h want 8c080010", instr); end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    n_compared++; if (pc !== 32'h0000_0110) begin n_mismatched++; $display("[TB] FAIL wait_pc_next: got %h want 00000110", pc); end
  endtask

  task automatic test_branch();
    // 0x114 + 0x3B*4 = 0x200
    applyStimulus(1'b1, 32'h1000_003B, 1'b0, 1'b0, 1'b0);
    n_compared++; if (pcplus4 !== 32'h0000_0114) begin n_mismatched++; $display("[TB] FAIL br_pcplus4: got %h want 00000114", pcplus4); end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_compared++; if (pc !== 32'h0000_0200) begin n_mismatched++; $display("[TB] FAIL br_to_200: got %h want 00000200", pc); end
    // imm = -1 at 0x200 loops back to itself
    applyStimulus(1'b1, 32'h1000_FFFF, 1'b0, 1'b0, 1'b0);
    n_compared++; if (pcplus4 !== 32'h0000_0204) begin n_mismatched++; $display("[TB] FAIL br_pcplus4_200: got %h want 00000204", pcplus4); end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_compared++; if (pc !== 32'h0000_0200) begin n_mismatched++; $display("[TB] FAIL br_neg1: got %h want 00000200", pc); end
    // imm = 3 at 0x200 -> 0x210
    applyStimulus(1'b1, 32'h1000_0003, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_compared++; if (pc !== 32'h0000_0210) begin n_mismatched++; $display("[TB] FAIL br_pos3: got %h want 00000210", pc); end
    // branch not taken falls through
    applyStimulus(1'b1, 32'h1000_0003, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    n_compared++; if (pc !== 32'h0000_0214) begin n_mismatched++; $display("[TB] FAIL br_not_taken: got %h want 00000214", pc); end
  endtask

  task automatic test_wrap_stall();
    // 0x218 - 0x87*4 = 0xFFFF_FFFC
    applyStimulus(1'b1, 32'h1000_FF79, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_compared++; if (pc !== 32'hFFFF_FFFC) begin n_mismatched++; $display("[TB] FAIL wrap_branch_down: got %h want fffffffc", pc); end
    applyStimulus(1'b1, 32'hAAAA_5555, 1'b0, 1'b0, 1'b0);
    n_compared++; if (pcplus4 !== 32'h0000_0000) begin n_mismatched++; $display("[TB] FAIL wrap_pcplus4: got %h want 00000000", pcplus4); end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b1);
      n_compared++; if (instr !== 32'hAAAA_5555) begin n_mismatched++; $display("[TB] FAIL stall_instr[%0d]: got %h want aaaa5555", i, instr); end
      n_compared++; if (pc !== 32'hFFFF_FFFC) begin n_mismatched++; $display("[TB] FAIL stall_pc[%0d]: got %h want fffffffc", i, pc); end
      n_compared++; if (instr_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL stall_valid[%0d]: got %b want 1", i, instr_valid); end
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    n_compared++; if (pc !== 32'h0000_0000) begin n_mismatched++; $display("[TB] FAIL wrap_seq: got %h want 00000000", pc); end
    // 0x4 - 8 wraps upward to 0xFFFF_FFFC
    applyStimulus(1'b1, 32'h1000_FFFE, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_compared++; if (pc !== 32'hFFFF_FFFC) begin n_mismatched++; $display("[TB] FAIL wrap_branch_up: got %h want fffffffc", pc); end
  endtask

  task automatic test_jump_priority();
    n_compared++; if (pc2 !== 32'h3000_0000) begin n_mismatched++; $display("[TB] FAIL jmp_start_pc: got %h want 30000000", pc2); end
    imem_ready2 = 1'b1;
    imem_rdata2 = 32'h0800_0040;
    @(negedge clk);
    imem_ready2 = 1'b0;
    n_compared++; if (instr_valid2 !== 1'b1) begin n_mismatched++; $display("[TB] FAIL jmp_valid: got %b want 1", instr_valid2); end
    advance2 = 1'b1;
    pcsrc2   = 1'b1;
    jump2    = 1'b1;
    @(negedge clk);
    advance2 = 1'b0;
    pcsrc2   = 1'b0;
    jump2    = 1'b0;
    n_compared++; if (pc2 !== 32'h3000_0100) begin n_mismatched++; $display("[TB] FAIL jmp_priority: got %h want 30000100", pc2); end
    imem_ready2 = 1'b1;
    imem_rdata2 = 32'h0BFF_FFFF;
    @(negedge clk);
    imem_ready2 = 1'b0;
    advance2 = 1'b1;
    jump2    = 1'b1;
    @(negedge clk);
    advance2 = 1'b0;
    jump2    = 1'b0;
    n_compared++; if (pc2 !== 32'h3FFF_FFFC) begin n_mismatched++; $display("[TB] FAIL jmp_max_target: got %h want 3ffffffc", pc2); end
  endtask

  task automatic test_reset_midfetch();
    n_compared++; if (imem_req !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mid_pre_req: got %b want 1", imem_req); end
    #2;
    reset_n = 1'b0;
    #1;
    n_compared++; if (imem_req !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_req_drop: got %b want 0", imem_req); end
    n_compared++; if (pc !== 32'h0000_0100) begin n_mismatched++; $display("[TB] FAIL mid_pc: got %h want 00000100", pc); end
    n_compared++; if (instr !== 32'h0) begin n_mismatched++; $display("[TB] FAIL mid_instr: got %h want 00000000", instr); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_compared++; if (imem_req !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mid_refetch_req: got %b want 1", imem_req); end
    n_compared++; if (imem_addr !== 32'h0000_0100) begin n_mismatched++; $display("[TB] FAIL mid_refetch_addr: got %h want 00000100", imem_addr); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset_n      = 1'b0;
    imem_rdata   = 32'h0;
    imem_ready   = 1'b0;
    advance      = 1'b0;
    pcsrc        = 1'b0;
    jump         = 1'b0;
    imem_rdata2  = 32'h0;
    imem_ready2  = 1'b0;
    advance2     = 1'b0;
    pcsrc2       = 1'b0;
    jump2        = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_wait_states();
    test_branch();
    test_wrap_stall();
    test_jump_priority();
    test_reset_midfetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
